conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming 3x3 convolution window generator; successor to the fixed 5x5 RAM-fetch/9-phase sequencer that feeds the 3x3 MAC.
- Accepts a raster-order pixel stream for an IMG_W x IMG_H frame and emits one 3x3 window per pixel ("same" convolution), with zero or replicate padding.
- Uses valid/ready handshakes on both sides, so it sits directly between the image RAM read port and the MAC array.

Parameters:
- DATA_W, 16, pixel width (Q6.10 like the weights; the block treats it as opaque bits).
- IMG_W, 32, frame width in pixels; must be >= 2 (elaboration error otherwise).
- IMG_H, 32, frame height in pixels; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a frame when busy=0.
- pad_mode  in  1  0=zero pad, 1=replicate (clamp) pad; sampled on accepted start.
- in_data  in  DATA_W  pixel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts pixel this cycle.
- win_data  out  9*DATA_W  taps t0..t8, t0 in LSBs, row-major; t4 = centre.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- out_row  out  $clog2(IMG_H)  centre row of the presented window.
- out_col  out  $clog2(IMG_W)  centre column of the presented window.
- out_last  out  1  presented window is (IMG_H-1, IMG_W-1).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final window handshake.

Behaviour:
- Reset (reset=0, asynchronous): in_ready, out_valid, win_data, out_row, out_col, out_last, busy and done = 0; all counters and the FSM return to IDLE.
- FSM:
  - IDLE -> RUN on start: clears counters, latches pad_mode, busy=1.
  - RUN -> FLUSH when the accepted count reaches IMG_W*IMG_H.
  - FLUSH -> IDLE on the out_last handshake; done=1 the next cycle and busy=0 the same cycle.
  - start while busy=1 is ignored.
- Handshake: a transfer occurs when valid&&ready on a rising edge. Input and output transfers may occur in the same cycle.
- Counters:
  - A = pixels accepted, E = windows emitted; raster index k = r*IMG_W + c.
  - in_ready = (state==RUN) && A < IMG_W*IMG_H && A < E + IMG_W + 2. in_ready is registered-safe, with no combinational path from out_ready.
- Window availability:
  - Window E needs pixel index min(r+1, IMG_H-1)*IMG_W + min(c+1, IMG_W-1). It is available when A exceeds that index.
  - Once available, out_valid rises on the next clock edge (1-cycle latency from the enabling input transfer).
- Output hold: while out_valid=1 and out_ready=0, win_data, out_row, out_col and out_last hold stable.
- Throughput: 1 window/cycle with no gaps when in_valid=out_ready=1 continuously. In FLUSH, the remaining windows stream back-to-back.
- Taps: tap (dr,dc) for dr,dc in {-1,0,1} = pixel(r+dr, c+dc).
  - Out-of-frame tap, pad_mode=0: value 0.
  - Out-of-frame tap, pad_mode=1: coordinates clamped to [0,IMG_H-1] x [0,IMG_W-1].
- Storage: at least 2*IMG_W+3 pixel entries (circular, or two line buffers plus a 3x3 register window). Storage never overflows because of the A-E cap.
- First window: out_valid for (0,0) occurs no earlier than the cycle after the (IMG_W+2)-th input transfer.
- Reset mid-frame aborts the frame without a done pulse. The next start begins a fresh frame.

Test Plan:
- IMG_W=4, IMG_H=3, pixel(r,c)=10r+c+1, pad_mode=0, in_valid=out_ready=1 -> first out_valid the cycle after the 6th input. Window(0,0)={0,0,0,0,1,2,0,11,12}. Window(1,1)={1,2,3,11,12,13,21,22,23}. Window(2,3)={13,14,0,23,24,0,0,0,0}. Exactly 12 windows; done 1 cycle after out_last.
- Same frame, pad_mode=1 -> (0,0)={1,1,2,1,1,2,11,11,12}; (2,3)={13,14,14,23,24,24,23,24,24}.
- out_ready held 0 after the first window -> window (0,0) held stable. in_ready drops after A=E+6 (6 pixels). On release, flow resumes with no window lost or duplicated.
- Random in_valid/out_ready gaps over a 32x32 frame -> window sequence matches the software model, out_row/out_col in raster order, exactly 1024 windows.
- start pulsed mid-frame -> ignored. Reset asserted at window 5 -> all outputs 0 immediately, no done. A new start then runs a full correct frame.
- in_valid held until A=12 and out_ready=1 -> FLUSH emits the final 4 windows on consecutive cycles with in_ready=0.

Source files
------------

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one padded 3x3 window per pixel out.
// Pixels live in a (2*IMG_W+3)-entry circular store addressed by raster index modulo depth.
module conv_window_gen #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     pad_mode,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [9*DATA_W-1:0]      win_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(IMG_H)-1:0] out_row,
   output logic [$clog2(IMG_W)-1:0] out_col,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);
   localparam int N  = IMG_W * IMG_H;
   localparam int D  = 2 * IMG_W + 3;
   localparam int CW = $clog2(N + 1);
   localparam int PW = $clog2(D);
   localparam int RW = $clog2(IMG_H);
   localparam int KW = $clog2(IMG_W);

   if (IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
      $error("conv_window_gen: IMG_W and IMG_H must both be >= 2");
   end

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]       a_q, e_q, lk_q;
   logic [RW-1:0]       lr_q;
   logic [KW-1:0]       lc_q;
   logic [PW-1:0]       wp_q, lp_q;
   logic                pad_q, ov_q, last_q, done_q;
   logic [RW-1:0]       row_q;
   logic [KW-1:0]       col_q;
   logic [9*DATA_W-1:0] win_q, win_d;
   logic [DATA_W-1:0]   mem_q [D];

   logic in_fire, out_fire, load_en;
   int   need;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = ov_q && out_ready;

   // Window lk_q needs its bottom-right in-frame neighbour; the pixel arriving this cycle counts.
   always_comb begin
      need = int'(lk_q) + ((int'(lr_q) < IMG_H - 1) ? IMG_W : 0) + ((int'(lc_q) < IMG_W - 1) ? 1 : 0);
      load_en = (state_q != IDLE) && (!ov_q || out_ready) && (int'(lk_q) < N) &&
                ((int'(a_q) + int'(in_fire)) > need);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (in_fire && int'(a_q) == N - 1) state_d = FLUSH;
         FLUSH:   if (out_fire && last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      in_ready = (state_q == RUN) && (int'(a_q) < N) && (int'(a_q) < int'(e_q) + IMG_W + 2);
   end

   always_comb begin
      int            dr, dc, s;
      logic [PW-1:0] ad;
      logic          oob;
      win_d = '0;
      dr = 0; dc = 0; s = 0; ad = '0; oob = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         for (int unsigned j = 0; j < 3; j++) begin
            dr  = int'(i) - 1;
            dc  = int'(j) - 1;
            oob = 1'b0;
            if ((dr < 0 && lr_q == '0) || (dr > 0 && int'(lr_q) == IMG_H - 1)) begin
               oob = 1'b1;
               dr  = 0;
            end
            if ((dc < 0 && lc_q == '0) || (dc > 0 && int'(lc_q) == IMG_W - 1)) begin
               oob = 1'b1;
               dc  = 0;
            end
            s = int'(lp_q) + D + dr * IMG_W + dc;
            if (s >= 2 * D)  s = s - 2 * D;
            else if (s >= D) s = s - D;
            ad = PW'(s);
            if (!oob || pad_q)
               win_d[(3*i+j)*DATA_W +: DATA_W] = (in_fire && ad == wp_q) ? in_data : mem_q[ad];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) mem_q[wp_q] <= in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= '0; e_q <= '0; lk_q <= '0; lr_q <= '0; lc_q <= '0;
         wp_q <= '0; lp_q <= '0; pad_q <= 1'b0; ov_q <= 1'b0; last_q <= 1'b0;
         row_q <= '0; col_q <= '0; win_q <= '0; done_q <= 1'b0;
      end else begin
         done_q <= (state_q == FLUSH) && (state_d == IDLE);
         if (state_q == IDLE && start) begin
            a_q <= '0; e_q <= '0; lk_q <= '0; lr_q <= '0; lc_q <= '0;
            wp_q <= '0; lp_q <= '0; pad_q <= pad_mode; ov_q <= 1'b0;
         end else begin
            if (in_fire) begin
               a_q  <= a_q + CW'(1);
               wp_q <= (int'(wp_q) == D - 1) ? '0 : wp_q + PW'(1);
            end
            if (out_fire) e_q <= e_q + CW'(1);
            if (load_en) begin
               ov_q   <= 1'b1;
               win_q  <= win_d;
               row_q  <= lr_q;
               col_q  <= lc_q;
               last_q <= (int'(lk_q) == N - 1);
               lk_q   <= lk_q + CW'(1);
               lp_q   <= (int'(lp_q) == D - 1) ? '0 : lp_q + PW'(1);
               if (int'(lc_q) == IMG_W - 1) begin
                  lc_q <= '0;
                  lr_q <= lr_q + RW'(1);
               end else begin
                  lc_q <= lc_q + KW'(1);
               end
            end else if (out_fire) begin
               ov_q <= 1'b0;
            end
         end
      end
   end

   assign win_data  = win_q;
   assign out_valid = ov_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_last  = last_q;
   assign done      = done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 4x3 frame: per-cycle comparison against a counting/window model.
module tb_conv_window_gen;
   localparam int DW = 16;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int WB = 9 * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          pad_mode;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [WB-1:0] win_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_row;
   logic [1:0]    out_col;
   logic          out_last;
   logic          busy;
   logic          done;

   conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) u_dut (
      .clk(clk), .reset(reset), .start(start), .pad_mode(pad_mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .win_data(win_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] img [N];
   logic [WB-1:0] cap_win [N];
   int            hs_cyc [N];
   int            first_ov_a;

   task automatic chk(input string nm, input logic [WB-1:0] got, input logic [WB-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic int need_idx(input int k);
      int r, c;
      r = k / W;
      c = k % W;
      return ((r + 1 < H) ? r + 1 : H - 1) * W + ((c + 1 < W) ? c + 1 : W - 1);
   endfunction

   function automatic logic [WB-1:0] model_win(input int k, input bit pad);
      logic [WB-1:0] w;
      int r, c, rr, cc;
      bit oob;
      w = '0;
      r = k / W;
      c = k % W;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            rr  = r + i - 1;
            cc  = c + j - 1;
            oob = (rr < 0) || (rr >= H) || (cc < 0) || (cc >= W);
            rr  = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
            cc  = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
            if (!oob || pad) w[(3*i+j)*DW +: DW] = img[rr*W + cc];
         end
      end
      return w;
   endfunction

   function automatic logic [WB-1:0] pack9(input int t [9]);
      logic [WB-1:0] w;
      w = '0;
      for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(t[i]);
      return w;
   endfunction

   // Model: A accepted, E emitted; outputs follow from availability and the A-E cap.
   initial begin : compare
      bit m_act, m_pad, m_done_pend, act_now, exp_ir, exp_ov, exp_done;
      int m_a, m_e, cyc_cnt;
      m_act = 0; m_pad = 0; m_done_pend = 0; m_a = 0; m_e = 0; cyc_cnt = 0;
      forever begin
         @(negedge clk);
         cyc_cnt++;
         if (!reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_win_data", win_data, 0);
            chk("rst_row_col_last", {out_row, out_col, out_last}, 0);
            m_act = 0; m_a = 0; m_e = 0; m_done_pend = 0;
         end else begin
            act_now     = m_act;
            exp_ir      = m_act && (m_a < N) && (m_a < m_e + W + 2);
            exp_ov      = m_act && (m_e < N) && (m_a > need_idx(m_e));
            exp_done    = m_done_pend;
            m_done_pend = 0;
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_ov);
            chk("busy", busy, m_act);
            chk("done", done, exp_done);
            if (exp_ov) begin
               chk("win_data", win_data, model_win(m_e, m_pad));
               chk("out_row", out_row, m_e / W);
               chk("out_col", out_col, m_e % W);
               chk("out_last", out_last, m_e == N - 1);
            end
            if (out_valid && first_ov_a < 0) first_ov_a = m_a;
            if (out_valid && out_ready && m_e < N) begin
               cap_win[m_e] = win_data;
               hs_cyc[m_e]  = cyc_cnt;
            end
            if (in_valid && exp_ir) m_a++;
            if (exp_ov && out_ready) begin
               m_e++;
               if (m_e == N) begin
                  m_act       = 0;
                  m_done_pend = 1;
               end
            end
            if (start && !act_now) begin
               m_act = 1; m_a = 0; m_e = 0; m_pad = pad_mode; first_ov_a = -1;
            end
         end
      end
   end

   // mode 0: full rate, 1: random gaps plus a stray start, 2: output stalled after first window
   task automatic run_frame(input bit pad, input int mode, input int abort_at);
      int idx, hs, hold;
      bit fin, rel, tin, tout, sd;
      idx = 0; hs = 0; hold = 0; fin = 0; rel = 0;
      @(posedge clk); #1;
      start = 1; pad_mode = pad;
      @(posedge clk); #1;
      start = 0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         in_valid = (idx < N) && ((mode != 1) || ($urandom_range(0, 3) != 0));
         in_data  = (idx < N) ? img[idx] : '0;
         case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = rel;
            default: out_ready = 1'b1;
         endcase
         start    = (mode == 1 && cyc == 7);
         pad_mode = ~pad;
         @(negedge clk);
         tin  = in_valid && in_ready;
         tout = out_valid && out_ready;
         sd   = done;
         if (mode == 2 && !rel && out_valid) begin
            hold++;
            if (hold == 8) begin
               chk("stall_accepted", idx, 6);
               chk("stall_in_ready", in_ready, 0);
               chk("stall_row_col", {out_row, out_col}, 0);
               rel = 1;
            end
         end
         @(posedge clk); #1;
         if (tin)  idx++;
         if (tout) hs++;
         if (sd)   fin = 1;
         if (abort_at >= 0 && hs == abort_at) begin
            reset = 0;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_in_ready", in_ready, 0);
            chk("abort_win_data", win_data, 0);
            chk("abort_row_col_last", {out_row, out_col, out_last}, 0);
            in_valid = 0; out_ready = 0; start = 0;
            repeat (2) @(posedge clk);
            #1 reset = 1;
            repeat (3) @(posedge clk);
            #1;
            return;
         end
      end
      in_valid = 0; out_ready = 0; start = 0;
      chk("frame_done_seen", fin, 1);
      chk("frame_window_count", hs, N);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : main
      int exp9 [9];
      reset = 0; start = 0; pad_mode = 0; in_data = '0; in_valid = 0; out_ready = 0;
      first_ov_a = -1;
      repeat (3) @(posedge clk);
      #1 reset = 1;

      for (int i = 0; i < N; i++) img[i] = DW'(10 * (i / W) + (i % W) + 1);
      run_frame(0, 0, -1);
      chk("first_valid_after_6_inputs", first_ov_a, 6);
      exp9 = '{0, 0, 0, 0, 1, 2, 0, 11, 12};
      chk("zero_win_0_0", cap_win[0], pack9(exp9));
      exp9 = '{1, 2, 3, 11, 12, 13, 21, 22, 23};
      chk("zero_win_1_1", cap_win[5], pack9(exp9));
      exp9 = '{13, 14, 0, 23, 24, 0, 0, 0, 0};
      chk("zero_win_2_3", cap_win[11], pack9(exp9));
      chk("flush_last4_consecutive", hs_cyc[11] - hs_cyc[8], 3);

      run_frame(1, 0, -1);
      exp9 = '{1, 1, 2, 1, 1, 2, 11, 11, 12};
      chk("rep_win_0_0", cap_win[0], pack9(exp9));
      exp9 = '{13, 14, 14, 23, 24, 24, 23, 24, 24};
      chk("rep_win_2_3", cap_win[11], pack9(exp9));

      run_frame(0, 2, -1);
      exp9 = '{0, 0, 0, 0, 1, 2, 0, 11, 12};
      chk("stall_win_0_0", cap_win[0], pack9(exp9));

      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(0, 65535));
         run_frame(1'($urandom_range(0, 1)), 1, -1);
      end

      for (int i = 0; i < N; i++) img[i] = DW'(100 + 7 * i);
      run_frame(0, 0, 5);
      chk("post_abort_idle", {busy, done, out_valid}, 0);
      run_frame(1, 1, -1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
